// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 key-schedule definitions: round count,
//               sequencer state encoding, the forward S-box table and the
//               round-constant table with their lookup helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_e;

  // Forward S-box, element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Indices past the table never occur in a legal schedule; return zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd0: v = RCON[0];
      4'd1: v = RCON[1];
      4'd2: v = RCON[2];
      4'd3: v = RCON[3];
      4'd4: v = RCON[4];
      4'd5: v = RCON[5];
      4'd6: v = RCON[6];
      4'd7: v = RCON[7];
      4'd8: v = RCON[8];
      4'd9: v = RCON[9];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_key_schedule_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_schedule_if
// Description : Round-key stream between the key scheduler (master) and the
//               inverse-cipher round engine (slave).
//                 rk_valid  master->slave  round key present
//                 rk_ready  slave->master  round key accepted this cycle
//                 rk[127:0] master->slave  round key, word 0 in [127:96]
//                 rk_round  master->slave  round index of rk (10 down to 0)
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_key_schedule_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;

  modport master (output rk_valid, output rk, output rk_round, input rk_ready);
  modport slave  (input rk_valid, input rk, input rk_round, output rk_ready);
endinterface
`default_nettype wire

// File: rtl/g_function.sv
`default_nettype none
// ============================================================================
// Module      : g_function
// Description : AES key-schedule word transform:
//               W_dash = SubWord(RotWord(W)) ^ {RCON[rounds], 24'h0}.
//                 W[31:0]      input word
//                 rounds[3:0]  round-constant index (0..9)
//                 W_dash[31:0] transformed word
// Revision    : 1.0 - initial release
// ============================================================================
module g_function
  import aes_pkg::*;
(
  input  wire logic [31:0] W,
  input  wire logic [3:0]  rounds,
  output logic      [31:0] W_dash
);

  logic [31:0] rot;
  logic [31:0] sub;

  // Rotate left by one byte: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  assign rot = {W[23:0], W[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign W_dash = sub ^ {rcon(rounds), 24'h000000};

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_schedule
// Description : Sequential AES-128 round-key generator for decryption. Runs
//               the key schedule forward to round key 10, then streams round
//               keys 10..0, undoing one schedule step per accepted beat.
//                 clk       system clock, rising edge
//                 rst       synchronous active-high reset
//                 start     begin a new schedule (sampled in IDLE only)
//                 key       cipher key, sampled with an accepted start
//                 busy      schedule in progress (FWD or REV)
//                 done      one-cycle pulse after round 0 is accepted
//                 rk_if     round-key stream (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               start,
  input  wire logic [127:0]       key,
  output logic                    busy,
  output logic                    done,
  aes_inv_key_schedule_if.master  rk_if
);

  localparam logic [3:0] LAST_FWD_CNT = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] TOP_ROUND    = 4'(NUM_ROUNDS);

  state_e       state_q, state_d;
  logic [127:0] kreg_q,  kreg_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic         done_q,  done_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] x01, x012, x0123;
  logic [31:0] g_word, g_out;
  logic [3:0]  g_round;
  logic        beat;

  assign k0 = kreg_q[127:96];
  assign k1 = kreg_q[95:64];
  assign k2 = kreg_q[63:32];
  assign k3 = kreg_q[31:0];

  // Reverse step: earlier words fall out of XORs of neighbouring words;
  // only p0 needs the transform, applied to the recovered last word p3.
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // Single shared transform: k3 / rcon[cnt] going forward,
  // p3 / rcon[cnt-1] going backward.
  assign g_word  = (state_q == REV) ? p3 : k3;
  assign g_round = (state_q == REV) ? (cnt_q - 4'd1) : cnt_q;

  g_function u_g (
    .W      (g_word),
    .rounds (g_round),
    .W_dash (g_out)
  );

  // The key-only XOR prefixes settle in parallel with the S-box, so each
  // forward word sees just one XOR after the transform output.
  assign x01   = k0 ^ k1;
  assign x012  = x01 ^ k2;
  assign x0123 = x012 ^ k3;

  assign n0 = g_out ^ k0;
  assign n1 = g_out ^ x01;
  assign n2 = g_out ^ x012;
  assign n3 = g_out ^ x0123;
  assign p0 = k0 ^ g_out;

  assign beat = (state_q == REV) && rk_if.rk_ready;

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          kreg_d  = key;
          cnt_d   = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        kreg_d = {n0, n1, n2, n3};
        if (cnt_q == LAST_FWD_CNT) begin
          cnt_d   = TOP_ROUND;
          state_d = REV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      REV: begin
        if (beat) begin
          if (cnt_q != 4'd0) begin
            kreg_d = {p0, p1, p2, p3};
            cnt_d  = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // All outputs come straight from flops or a decode of the state flop.
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign rk_if.rk_valid = (state_q == REV);
  assign rk_if.rk       = kreg_q;
  assign rk_if.rk_round = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_key_schedule
// Description : Self-checking bench for aes_inv_key_schedule: FIPS-197 and
//               all-zero directed keys, backpressure, ignored start pulses,
//               mid-stream reset, back-to-back start and random keys against
//               a forward-expansion reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_schedule;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         done;

  aes_inv_key_schedule_if rk_if ();

  aes_inv_key_schedule dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .busy  (busy),
    .done  (done),
    .rk_if (rk_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: textbook forward word expansion w[0..43].
  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc[i/4 - 1];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge with the DUT idle; starts a schedule immediately.
  task automatic run(input logic [127:0] k, input bit stall, input bit poke);
    int waited;
    int r;
    int guard;
    expand_key(k);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    key   = ~k;
    check("busy_after_start", busy, 1);
    waited = 0;
    while (!rk_if.rk_valid && waited < 40) begin
      start = (poke && waited == 3);
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    check("first_beat_latency", waited, 10);
    r = 10;
    guard = 0;
    while (r >= 0 && guard < 300) begin
      check("rk_valid", rk_if.rk_valid, 1);
      check("rk", rk_if.rk, exp_rk[r]);
      check("rk_round", rk_if.rk_round, r[3:0]);
      check("done_early", done, 0);
      start = (poke && r == 6);
      rk_if.rk_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rk_if.rk_ready) begin
        got_rk[r] = rk_if.rk;
        r--;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    rk_if.rk_ready = 1'b0;
    check("schedule_timeout", guard < 300, 1);
    check("done_pulse", done, 1);
    check("busy_after_done", busy, 0);
    check("valid_after_done", rk_if.rk_valid, 0);
  endtask

  task automatic reset_mid_rev(input logic [127:0] k);
    int guard;
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(rk_if.rk_valid && rk_if.rk_round == 4'd5) && guard < 60) begin
      rk_if.rk_ready = 1'b1;
      @(negedge clk);
      guard++;
    end
    check("reach_round5", guard < 60, 1);
    rk_if.rk_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", rk_if.rk_valid, 0);
    check("rst_rk", rk_if.rk, 0);
    check("rst_round", rk_if.rk_round, 0);
    check("rst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] rkey;
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    rk_if.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", rk_if.rk_valid, 0);
    check("reset_rk", rk_if.rk, 0);
    check("reset_round", rk_if.rk_round, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // rk_ready with nothing valid must not start anything.
    rk_if.rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_valid", rk_if.rk_valid, 0);
    check("idle_ready_busy", busy, 0);
    rk_if.rk_ready = 1'b0;

    run(FIPS_KEY, 1'b0, 1'b0);
    check("fips_rk10", got_rk[10], FIPS_RK10);
    check("fips_rk1", got_rk[1], FIPS_RK1);
    check("fips_rk0", got_rk[0], FIPS_KEY);

    run(FIPS_KEY, 1'b1, 1'b0);
    check("stall_rk10", got_rk[10], FIPS_RK10);

    run(FIPS_KEY, 1'b0, 1'b1);
    check("poke_rk10", got_rk[10], FIPS_RK10);
    check("poke_rk0", got_rk[0], FIPS_KEY);

    reset_mid_rev(FIPS_KEY);

    run(128'h0, 1'b0, 1'b0);
    check("zero_rk10", got_rk[10], ZERO_RK10);
    check("zero_rk1", got_rk[1], ZERO_RK1);
    run(FIPS_KEY, 1'b0, 1'b0);
    check("b2b_rk10", got_rk[10], FIPS_RK10);

    for (int n = 0; n < 20; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run(rkey, 1'b1, 1'b0);
      check("rand_rk0", got_rk[0], rkey);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
